// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the processor datapath and hazard_ctrl.
// The datapath (master) drives decoded ID fields, the EX branch outcome and
// the data-memory handshake; the controller (slave) returns the sequencing
// and forwarding controls.
interface hazard_ctrl_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [REG_W-1:0] id_dest;
  logic             id_write_reg;
  logic             id_load;
  logic             id_jump;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ack;
  logic             pc_hold;
  logic             flush_ifid;
  logic             bubble_ex;
  logic             freeze;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_write_reg, id_load, id_jump, ex_branch_taken, mem_req, mem_ack,
    input  pc_hold, flush_ifid, bubble_ex, freeze, fwd_a, fwd_b, mem_err,
           stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_write_reg, id_load, id_jump, ex_branch_taken, mem_req, mem_ack,
    output pc_hold, flush_ifid, bubble_ex, freeze, fwd_a, fwd_b, mem_err,
           stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Sequencing controller for the 5-stage pipeline: load-use stall, branch and
// jump flushes, memory-wait freeze with timeout, and EX operand forwarding
// driven from a private shadow of the EX/MEM/WB destination state.
module hazard_ctrl #(
  parameter int REG_W   = 3,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic {S_RUN, S_MEM_WAIT} state_t;

  // Statistics counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             ex_valid_q, ex_valid_d;
  logic             ex_write_q, ex_write_d;
  logic             ex_load_q, ex_load_d;
  logic             ex_uses_rs_q, ex_uses_rs_d;
  logic             ex_uses_rt_q, ex_uses_rt_d;
  logic [REG_W-1:0] ex_dest_q, ex_dest_d;
  logic [REG_W-1:0] ex_rs_q, ex_rs_d;
  logic [REG_W-1:0] ex_rt_q, ex_rt_d;
  logic             mem_valid_q, mem_valid_d;
  logic             mem_write_q, mem_write_d;
  logic             mem_load_q, mem_load_d;
  logic [REG_W-1:0] mem_dest_q, mem_dest_d;
  logic             wb_valid_q, wb_valid_d;
  logic             wb_write_q, wb_write_d;
  logic [REG_W-1:0] wb_dest_q, wb_dest_d;

  logic timeout_hit, freeze, load_use, jump_flush, branch;
  logic pc_hold, flush_ifid, bubble_ex;

  // A load sitting in MEM has no data yet, so only a non-load can feed EX/MEM;
  // by WB every writer (load included) has its result.
  function automatic logic [1:0] fwd_sel(input logic uses, input logic [REG_W-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (uses && (src != '0)) begin
      if (mem_valid_q && mem_write_q && !mem_load_q && (mem_dest_q == src))
        sel = 2'b01;
      else if (wb_valid_q && wb_write_q && (wb_dest_q == src))
        sel = 2'b10;
    end
    return sel;
  endfunction

  // Hazard detection and priority: freeze > branch flush > jump flush > load-use.
  always_comb begin
    timeout_hit = (state_q == S_MEM_WAIT) && (to_cnt_q == TO_W'(TIMEOUT));
    freeze      = bus.mem_req && !bus.mem_ack && !timeout_hit;
    branch      = bus.ex_branch_taken;
    jump_flush  = bus.id_valid && bus.id_jump;
    load_use    = bus.id_valid && ex_valid_q && ex_load_q && (ex_dest_q != '0) &&
                  ((bus.id_uses_rs && (bus.id_rs == ex_dest_q)) ||
                   (bus.id_uses_rt && (bus.id_rt == ex_dest_q)));
    pc_hold     = !freeze && !branch && !jump_flush && load_use;
    bubble_ex   = !freeze && (branch || (load_use && !jump_flush));
    flush_ifid  = !freeze && (branch || jump_flush);
  end

  assign bus.pc_hold    = pc_hold;
  assign bus.flush_ifid = flush_ifid;
  assign bus.bubble_ex  = bubble_ex;
  assign bus.freeze     = freeze;
  assign bus.fwd_a      = fwd_sel(ex_uses_rs_q, ex_rs_q);
  assign bus.fwd_b      = fwd_sel(ex_uses_rt_q, ex_rt_q);
  assign bus.mem_err    = mem_err_q;
  assign bus.stall_cnt  = stall_cnt_q;

  // Shadow advance: ID -> EX -> MEM -> WB unless frozen; bubbles clear the use bits too.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_write_d   = ex_write_q;
    ex_load_d    = ex_load_q;
    ex_uses_rs_d = ex_uses_rs_q;
    ex_uses_rt_d = ex_uses_rt_q;
    ex_dest_d    = ex_dest_q;
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    mem_valid_d  = mem_valid_q;
    mem_write_d  = mem_write_q;
    mem_load_d   = mem_load_q;
    mem_dest_d   = mem_dest_q;
    wb_valid_d   = wb_valid_q;
    wb_write_d   = wb_write_q;
    wb_dest_d    = wb_dest_q;
    if (!freeze) begin
      ex_valid_d   = bus.id_valid && !bubble_ex;
      ex_write_d   = bus.id_write_reg;
      ex_load_d    = bus.id_load;
      ex_uses_rs_d = bus.id_uses_rs && ex_valid_d;
      ex_uses_rt_d = bus.id_uses_rt && ex_valid_d;
      ex_dest_d    = bus.id_dest;
      ex_rs_d      = bus.id_rs;
      ex_rt_d      = bus.id_rt;
      mem_valid_d  = ex_valid_q;
      mem_write_d  = ex_write_q;
      mem_load_d   = ex_load_q;
      mem_dest_d   = ex_dest_q;
      wb_valid_d   = mem_valid_q;
      wb_write_d   = mem_write_q;
      wb_dest_d    = mem_dest_q;
    end
  end

  // Memory-wait FSM and stall statistics.
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = (pc_hold || freeze) ? sat_inc(stall_cnt_q) : stall_cnt_q;
    case (state_q)
      S_RUN: begin
        if (freeze) begin
          state_d  = S_MEM_WAIT;
          to_cnt_d = TO_W'(1);
        end
      end
      S_MEM_WAIT: begin
        if (bus.mem_ack || !bus.mem_req) begin
          state_d  = S_RUN;
          to_cnt_d = '0;
        end else if (timeout_hit) begin
          state_d   = S_RUN;
          to_cnt_d  = '0;
          mem_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d  = S_RUN;
        to_cnt_d = '0;
      end
    endcase
  end

  // ---- control registers: FSM, counters, shadow valid/write/load/use bits ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RUN;
      to_cnt_q     <= '0;
      mem_err_q    <= 1'b0;
      stall_cnt_q  <= '0;
      ex_valid_q   <= 1'b0;
      ex_write_q   <= 1'b0;
      ex_load_q    <= 1'b0;
      ex_uses_rs_q <= 1'b0;
      ex_uses_rt_q <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_load_q   <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_write_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      mem_err_q    <= mem_err_d;
      stall_cnt_q  <= stall_cnt_d;
      ex_valid_q   <= ex_valid_d;
      ex_write_q   <= ex_write_d;
      ex_load_q    <= ex_load_d;
      ex_uses_rs_q <= ex_uses_rs_d;
      ex_uses_rt_q <= ex_uses_rt_d;
      mem_valid_q  <= mem_valid_d;
      mem_write_q  <= mem_write_d;
      mem_load_q   <= mem_load_d;
      wb_valid_q   <= wb_valid_d;
      wb_write_q   <= wb_write_d;
    end
  end

  // ---- register-index fields: qualified by the valid bits, so never reset ----
  always_ff @(posedge clk) begin
    ex_dest_q  <= ex_dest_d;
    ex_rs_q    <= ex_rs_d;
    ex_rt_q    <= ex_rt_d;
    mem_dest_q <= mem_dest_d;
    wb_dest_q  <= wb_dest_d;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a cycle-by-cycle vector table covering
// load-use, forwarding, R0, branch/jump flush and a short memory wait, then
// hand-written timeout and reset-during-wait sequences.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 15;

  typedef struct {
    string       name;
    logic        v;
    logic [2:0]  rs, rt;
    logic        urs, urt;
    logic [2:0]  dest;
    logic        wr, ld, jmp, br, mreq, mack;
    logic [24:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];

  hazard_ctrl_if #(.REG_W(3), .CNT_W(16)) bus ();

  hazard_ctrl #(.REG_W(3), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] ev(int h, int f, int b, int z, int fa, int fb, int e, int c);
    return {h != 0, f != 0, b != 0, z != 0, 2'(fa), 2'(fb), e != 0, 16'(c)};
  endfunction

  function automatic vec_t mk(string n, int v, int rs, int rt, int urs, int urt, int dest,
                              int wr, int ld, int jmp, int br, int mreq, int mack,
                              logic [24:0] exp);
    vec_t r;
    r.name = n;   r.v = v != 0;     r.rs = 3'(rs);     r.rt = 3'(rt);
    r.urs = urs != 0; r.urt = urt != 0; r.dest = 3'(dest);
    r.wr = wr != 0;   r.ld = ld != 0;   r.jmp = jmp != 0; r.br = br != 0;
    r.mreq = mreq != 0; r.mack = mack != 0; r.exp = exp;
    return r;
  endfunction

  task automatic drive(input vec_t r);
    bus.id_valid = r.v;      bus.id_rs = r.rs;       bus.id_rt = r.rt;
    bus.id_uses_rs = r.urs;  bus.id_uses_rt = r.urt; bus.id_dest = r.dest;
    bus.id_write_reg = r.wr; bus.id_load = r.ld;     bus.id_jump = r.jmp;
    bus.ex_branch_taken = r.br; bus.mem_req = r.mreq; bus.mem_ack = r.mack;
  endtask

  task automatic check(input string name, input logic [24:0] exp);
    logic [24:0] act;
    act = {bus.pc_hold, bus.flush_ifid, bus.bubble_ex, bus.freeze,
           bus.fwd_a, bus.fwd_b, bus.mem_err, bus.stall_cnt};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s hold/flush/bub/frz/fa/fb/err/cnt act=%b%b%b%b %b %b %b %0d exp=%b%b%b%b %b %b %b %0d",
               name, act[24], act[23], act[22], act[21], act[20:19], act[18:17], act[16], act[15:0],
               exp[24], exp[23], exp[22], exp[21], exp[20:19], exp[18:17], exp[16], exp[15:0]);
    end
  endtask

  // One cycle with only the memory handshake driven (ID empty).
  task automatic mem_cycle(input logic req, input logic ack, input string name, input logic [24:0] exp);
    @(posedge clk); #1;
    drive(mk("", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, req, ack, '0));
    @(negedge clk);
    check(name, exp);
  endtask

  // mem_req held with no ack from RUN: freeze for TIMEOUT cycles, drops on the next,
  // mem_err appears the cycle after that.
  task automatic run_timeout(input int cnt0, input string tag);
    for (int k = 0; k <= TIMEOUT; k++)
      mem_cycle(1'b1, 1'b0, $sformatf("%s_k%0d", tag, k),
                ev(0, 0, 0, (k < TIMEOUT) ? 1 : 0, 0, 0, 0, cnt0 + k));
    mem_cycle(1'b0, 1'b0, {tag, "_err"}, ev(0, 0, 0, 0, 0, 0, 1, cnt0 + TIMEOUT));
  endtask

  initial begin
    //              name            v rs rt us ut d wr ld j  br mq ma   h f b z fa fb e cnt
    tbl.push_back(mk("ld_r3",       1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,0)));
    tbl.push_back(mk("add_lu",      1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, 0, ev(1,0,1,0,0,0,0,0)));
    tbl.push_back(mk("add_held",    1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,1)));
    tbl.push_back(mk("add_fwd_wb",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(0,0,0,0,2,0,0,1)));
    tbl.push_back(mk("add_r2",      1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,1)));
    tbl.push_back(mk("sub_r5",      1, 2, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,1)));
    tbl.push_back(mk("sub_fwd_mem", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(0,0,0,0,1,1,0,1)));
    tbl.push_back(mk("wr_r0",       1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,1)));
    tbl.push_back(mk("rd_r0",       1, 0, 0, 1, 1, 6, 1, 0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,1)));
    tbl.push_back(mk("r0_nofwd",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,1)));
    tbl.push_back(mk("ld_r0",       1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,1)));
    tbl.push_back(mk("r0_nostall",  1, 0, 0, 1, 1, 6, 1, 0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,1)));
    tbl.push_back(mk("r0_nofwd2",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,1)));
    tbl.push_back(mk("ld_r5",       1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,1)));
    tbl.push_back(mk("br_over_lu",  1, 5, 2, 1, 1, 6, 1, 0, 0, 1, 0, 0, ev(0,1,1,0,0,0,0,1)));
    tbl.push_back(mk("after_br",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,1)));
    tbl.push_back(mk("jmp",         1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, ev(0,1,0,0,0,0,0,1)));
    tbl.push_back(mk("ld_r2",       1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,1)));
    tbl.push_back(mk("frz1",        1, 2, 3, 1, 1, 4, 1, 0, 0, 0, 1, 0, ev(0,0,0,1,0,0,0,1)));
    tbl.push_back(mk("frz2",        1, 2, 3, 1, 1, 4, 1, 0, 0, 0, 1, 0, ev(0,0,0,1,0,0,0,2)));
    tbl.push_back(mk("frz3",        1, 2, 3, 1, 1, 4, 1, 0, 0, 0, 1, 0, ev(0,0,0,1,0,0,0,3)));
    tbl.push_back(mk("ack_lu",      1, 2, 3, 1, 1, 4, 1, 0, 0, 0, 1, 1, ev(1,0,1,0,0,0,0,4)));
    tbl.push_back(mk("add_held2",   1, 2, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,5)));
    tbl.push_back(mk("fwd_aft_frz", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(0,0,0,0,2,0,0,5)));

    drive(mk("", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset", ev(0,0,0,0,0,0,0,0));

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      @(negedge clk);
      check(tbl[i].name, tbl[i].exp);
    end

    run_timeout(5, "tmo");
    mem_cycle(1'b0, 1'b0, "err_sticky", ev(0,0,0,0,0,0,1,20));

    mem_cycle(1'b1, 1'b0, "wait0", ev(0,0,0,1,0,0,1,20));
    mem_cycle(1'b1, 1'b0, "wait1", ev(0,0,0,1,0,0,1,21));
    mem_cycle(1'b1, 1'b0, "wait2", ev(0,0,0,1,0,0,1,22));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    drive(mk("", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0));
    @(negedge clk);
    check("rst_midwait", ev(0,0,0,0,0,0,0,0));

    run_timeout(0, "tmo2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
